// File: rtl/datapath.sv
// datapath: PC, IR, accumulator, 16x8 register file and ALU of the 8-bit CPU.
// Every enable reads pre-edge state; the controller sequences fetch/execute.
module datapath #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '1
) (
    input  logic            clk,
    input  logic            CLB,
    input  logic            LoadIR,
    input  logic            IncPC,
    input  logic            SelPC,
    input  logic            LoadPC,
    input  logic            LoadReg,
    input  logic            LoadAcc,
    input  logic [1:0]      SelAcc,
    input  logic [3:0]      SelALU,
    output logic [PC_W-1:0] imem_addr,
    input  logic [7:0]      imem_data,
    output logic [3:0]      opcode,
    output logic            Z,
    output logic            C,
    output logic [7:0]      acc
);
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q, ir_d, acc_q, acc_d, res, rdat;
    logic [7:0]      rf_q [16];
    logic            z_q, z_d, c_q, c_d, cn;
    logic [3:0]      idx;
    logic [8:0]      sum;

    assign idx       = ir_q[3:0];
    assign rdat      = rf_q[idx];
    assign imem_addr = pc_q;
    assign opcode    = ir_q[7:4];
    assign Z         = z_q;
    assign C         = c_q;
    assign acc       = acc_q;

    always_comb begin
        sum = '0;
        res = acc_q;
        cn  = 1'b0;
        case (SelALU)
            4'b1000: begin
                sum = {1'b0, acc_q} + {1'b0, rdat};
                res = sum[7:0];
                cn  = sum[8];
            end
            // carry out of A + ~B + 1 means no borrow
            4'b1100: begin
                sum = {1'b0, acc_q} + {1'b0, ~rdat} + 9'd1;
                res = sum[7:0];
                cn  = sum[8];
            end
            4'b0100: res = ~(acc_q | rdat);
            4'b0001: begin
                res = ir_q[4] ? {acc_q[6:0], 1'b0} : {1'b0, acc_q[7:1]};
                cn  = ir_q[4] ? acc_q[7] : acc_q[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        pc_d  = LoadPC ? (SelPC ? PC_W'(rdat) : PC_W'(idx)) : IncPC ? pc_q + PC_W'(1) : pc_q;
        ir_d  = LoadIR ? imem_data : ir_q;
        acc_d = !LoadAcc ? acc_q : SelAcc == 2'b00 ? res : SelAcc == 2'b01 ? acc_q :
                SelAcc == 2'b10 ? rdat : {4'b0000, idx};
        z_d   = (LoadAcc && SelAcc != 2'b01) ? (acc_d == 8'd0) : z_q;
        c_d   = (LoadAcc && SelAcc == 2'b00) ? cn : c_q;
    end

    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            pc_q  <= RESET_PC;
            ir_q  <= '0;
            acc_q <= '0;
            z_q   <= 1'b0;
            c_q   <= 1'b0;
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            acc_q <= acc_d;
            z_q   <= z_d;
            c_q   <= c_d;
            if (LoadReg) rf_q[idx] <= acc_q;
        end
    end
endmodule

// File: doc/datapath.md
# datapath

Execution datapath of the 8-bit CPU, the consumer of the control-word outputs of `controller`. It holds the program counter, instruction register, accumulator, a 16-entry register file and the ALU. It presents the fetch address to instruction memory and returns `opcode`, `Z` and `C` to the controller. Each instruction takes two cycles, driven entirely by the controller: one fetch cycle (`LoadIR`=1) and one execute cycle.

## Interface
- `PC_W`, 8: program counter and instruction-memory address width.
- `RESET_PC`, all ones (8'hFF): PC value after reset.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `CLB`  in  1  asynchronous, active-low reset.
- `LoadIR`  in  1  IR <= `imem_data`.
- `IncPC`  in  1  PC <= PC+1 (mod 2^PC_W).
- `SelPC`  in  1  PC load source: 1 = R[IR[3:0]] (zero-extended/truncated to PC_W), 0 = IMM (IR[3:0] zero-extended).
- `LoadPC`  in  1  PC <= source selected by `SelPC`.
- `LoadReg`  in  1  R[IR[3:0]] <= ACC.
- `LoadAcc`  in  1  ACC <= source selected by `SelAcc`.
- `SelAcc`  in  2  00 = ALU result, 01 = ACC (hold), 10 = R[IR[3:0]], 11 = IMM (IR[3:0] zero-extended).
- `SelALU`  in  4  ALU function; encoding under Operation.
- `imem_addr`  out  PC_W  equals PC (registered value).
- `imem_data`  in  8  instruction byte at `imem_addr` (combinational memory read).
- `opcode`  out  4  IR[7:4].
- `Z`  out  1  zero flag register.
- `C`  out  1  carry flag register.
- `acc`  out  8  accumulator value (observation/debug).

## Operation
- Instruction format: IR[7:4] = opcode, IR[3:0] = register index or 4-bit immediate (IMM).
- ALU operands: A = ACC, B = R[IR[3:0]]. Result is 8-bit, plus carry-out Cn.
  - 1000 ADD: {Cn,res} = A+B.
  - 1100 SUB: res = A-B, computed as A + ~B + 1; Cn = 1 when there is no borrow (A >= B unsigned).
  - 0100 NOR: res = ~(A|B); Cn = 0.
  - 0001 SHIFT: if IR[4]=1, res = A<<1 with Cn = A[7]. If IR[4]=0, res = A>>1 (zero fill) with Cn = A[0]. Opcode 11 shifts left and opcode 12 shifts right.
  - Any other code (including 0000 and 0010): res = A, Cn = 0.
- Flag update happens only when `LoadAcc`=1:
  - `SelAcc`=00: Z <= (res==0), C <= Cn.
  - `SelAcc`=10 or 11: Z <= (new ACC==0), C unchanged.
  - `SelAcc`=01: both flags unchanged.
- PC update priority: `LoadPC` > `IncPC` > hold.
- All enables act independently in the same cycle. Every read uses pre-edge values:
  - `LoadReg` with `LoadAcc` stores the old ACC.
  - `LoadIR` in the same cycle as `LoadReg`/`LoadPC` uses the old IR[3:0] for indexing.
- Register file: 16 × 8, no read port other than index IR[3:0].

## Timing
- Reset (`CLB`=0, asynchronous): PC = RESET_PC, IR = 8'h00, ACC = 0, all R[i] = 0, Z = 0, C = 0. Outputs reflect these values immediately.
- After reset release, the controller first executes the reset IR (opcode 0 WAIT, IncPC=1), so PC wraps from 8'hFF to 0. The first fetch is therefore from address 0.
- Fetch cycle: IR is captured at the edge. `opcode` is valid in the following (execute) cycle.
- Execute cycle: PC, ACC, R and flags update at the closing edge. `imem_addr` shows the new PC in the next (fetch) cycle.
- Conditional jumps consume the `Z`/`C` values registered before the execute cycle, so flags from instruction N steer a jump at N+1.
- Reset asserted mid-cycle overrides all enables. No partial updates survive.
- PC increment wraps at 2^PC_W-1 to 0 with no flag effect.

## Test plan
- Reset: hold `CLB`=0 with all enables at 1 and toggle the clock. Require `imem_addr`=8'hFF, `opcode`=0, `acc`=0, Z=0, C=0, and no state change. After release, one `IncPC` cycle gives `imem_addr`=0.
- ADD carry: ACC <= IMM 9; R3 <= ACC; ACC <= IMM 15 (0x0F); ADD with R3 → 0x18, C=0. Then build ACC=0xFF via NOR of zeros, ADD R3(9) → 0x08, C=1, Z=0.
- SUB: ACC=5, R1=5, SUB → 0, Z=1, C=1. Then ACC=3, SUB R1 → 0xFE, Z=0, C=0.
- Shifts: ACC=0x81 (NOR of 0x7E). Opcode 11 SHIFT → 0x02, C=1. Opcode 12 SHIFT on 0x02 → 0x01, C=0, Z=0.
- PC control:
  - `LoadPC`=1, `SelPC`=0, IR=0x7A → PC=0x0A.
  - `SelPC`=1 with R[4]=0x55 and IR=0x64 → PC=0x55.
  - `LoadPC` and `IncPC` both 1 → load wins.
  - `IncPC` alone at 0xFF → 0x00.
- Simultaneous and reset: `LoadReg`+`LoadAcc` (SelAcc=11) in one cycle → register gets old ACC. Reset pulse between fetch and execute → all state returns to reset values and no execute-cycle update occurs.
